shift_arb_seq: RTL and testbench

Two-requester arbiter and sequencer for the 32-bit one-fill right barrel shifter. It accepts shift jobs over valid/ready from two clients and grants them round-robin. It drives the shared shifter's data and 5-bit load inputs from internal registers, and splits shift amounts of 32–63 into two passes. Results return over a valid/ready response channel tagged with the requester ID.

---
 rtl/shift_arb_seq.sv | 111 +++++++++++
 tb/tb_shift_arb_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_arb_seq.sv
// Two-requester round-robin arbiter and sequencer for a shared 32-bit one-fill right barrel shifter.
// Optional macro SHIFT_ARB_ZERO_BYPASS_EN: zero-amount jobs skip the shifter and go straight to RESP.
module shift_arb_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [5:0]  req0_amt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [5:0]  req1_amt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic [31:0] sh_in,
  output logic [4:0]  sh_load,
  input  logic [31:0] sh_out,
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam int AMT_W  = 6;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_data;
  logic [AMT_W-1:0]    r_amt;
  logic [4:0]          r_load;
  logic                r_id;
  logic                r_ptr;

  logic                w_idle;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_sel;
  logic [DATA_W-1:0]   w_req_data;
  logic [AMT_W-1:0]    w_req_amt;

  // The shifter load port is only 5 bits wide, so clamp anything above 31.
  function automatic logic [4:0] sat_load(input logic [AMT_W-1:0] a);
    return (a > 6'd31) ? 5'd31 : a[4:0];
  endfunction

  // Contention goes to whichever requester was not granted last.
  assign w_idle     = (r_state == IDLE) && rst_n;
  assign w_gnt0     = w_idle && req0_valid && (!req1_valid || r_ptr);
  assign w_gnt1     = w_idle && req1_valid && (!req0_valid || !r_ptr);
  assign w_sel      = w_gnt1;
  assign w_req_data = w_sel ? req1_data : req0_data;
  assign w_req_amt  = w_sel ? req1_amt  : req0_amt;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign sh_in      = r_data;
  assign sh_load    = r_load;
  assign rsp_data   = r_data;
  assign rsp_id     = r_id;
  assign rsp_valid  = (r_state == RESP);
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_amt   <= '0;
      r_load  <= '0;
      r_id    <= 1'b0;
      r_ptr   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_data <= w_req_data;
            r_amt  <= w_req_amt;
            r_id   <= w_sel;
            r_ptr  <= w_sel;
            r_load <= sat_load(w_req_amt);
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
            r_state <= (w_req_amt == 6'd0) ? RESP : PASS1;
`else
            r_state <= PASS1;
`endif
          end
        end
        // Amounts of 32-63 need a second pass for the remainder beyond 31.
        PASS1: begin
          r_data <= sh_out;
          if (r_amt > 6'd31) begin
            r_load  <= sat_load(r_amt - 6'd31);
            r_state <= PASS2;
          end else begin
            r_state <= RESP;
          end
        end
        PASS2: begin
          r_data  <= sh_out;
          r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arb_seq.sv
// Directed bench for shift_arb_seq with a behavioural one-fill right shifter on the sh_* ports.
module tb_shift_arb_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [5:0]  req0_amt, req1_amt;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data, sh_in, sh_out;
  logic [4:0]  sh_load;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SHIFT_ARB_ZERO_BYPASS_EN
  localparam int ZERO_K = 0;
`else
  localparam int ZERO_K = 1;
`endif

  shift_arb_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amt(req1_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .sh_in(sh_in), .sh_load(sh_load), .sh_out(sh_out), .busy(busy)
  );

  assign sh_out = (sh_in >> sh_load) | ~(32'hFFFF_FFFF >> sh_load);

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one job, wait for grant, then measure edges from accept to rsp_valid.
  task automatic run_job(input string tag, input bit r, input logic [31:0] d, input logic [5:0] a,
                         input logic [31:0] exp_d, input int exp_k,
                         input logic [4:0] ld1, input logic [4:0] ld2);
    int k;
    bit got;
    if (r) begin req1_valid = 1'b1; req1_data = d; req1_amt = a; end
    else   begin req0_valid = 1'b1; req0_data = d; req0_amt = a; end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((r ? req1_ready : req0_ready) == 1'b1) got = 1'b1;
      else tick();
    end
    chk({tag, "_rdy"}, 32'(got), 32'd1);
    if (!got) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 8) begin
      if (k == 0) begin
        chk({tag, "_shin"}, sh_in, d);
        chk({tag, "_ld1"}, 32'(sh_load), 32'(ld1));
      end
      if (k == 1) chk({tag, "_ld2"}, 32'(sh_load), 32'(ld2));
      tick();
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(exp_k));
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_id"}, 32'(rsp_id), 32'(r));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, busy, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h1111_1111; req0_amt = 6'd3;
    req1_valid = 1'b1; req1_data = 32'h2222_2222; req1_amt = 6'd5;
    tick(); tick();
    chk("rst_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_rspd", rsp_data, 32'd0);
    chk("rst_rspid", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_shin", sh_in, 32'd0);
    chk("rst_shld", 32'(sh_load), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Round-robin with both requesters continuously valid.
    req0_valid = 1'b1; req0_data = 32'h1; req0_amt = 6'd1;
    req1_valid = 1'b1; req1_data = 32'h2; req1_amt = 6'd1;
    #1;
    chk("rr_g0", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    chk("rr_busy", 32'(busy), 32'd1);
    chk("rr_norn", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    chk("rr_v0", 32'(rsp_valid), 32'd1);
    chk("rr_d0", rsp_data, 32'h8000_0000);
    chk("rr_id0", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("rr_g1", {30'd0, req1_ready, req0_ready}, 32'd2);
    tick();
    tick();
    chk("rr_v1", 32'(rsp_valid), 32'd1);
    chk("rr_d1", rsp_data, 32'h8000_0001);
    chk("rr_id1", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("rr_g2", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    run_job("a4",  1'b0, 32'h0000_00F0, 6'd4,  32'hF000_000F, 1, 5'd4,  5'd0);
    run_job("a40", 1'b1, 32'h0000_0000, 6'd40, 32'hFFFF_FFFF, 2, 5'd31, 5'd9);
    run_job("a31", 1'b0, 32'h0000_0000, 6'd31, 32'hFFFF_FFFE, 1, 5'd31, 5'd0);
    run_job("a63", 1'b1, 32'h0000_0000, 6'd63, 32'hFFFF_FFFF, 2, 5'd31, 5'd31);
    run_job("a32", 1'b0, 32'h0000_0000, 6'd32, 32'hFFFF_FFFF, 2, 5'd31, 5'd1);

    // Consumer stalls in RESP while another request waits.
    req0_valid = 1'b1; req0_data = 32'h1234_5678; req0_amt = 6'd8;
    #1;
    chk("st_rdy", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 32'hA5A5_A5A5; req1_amt = 6'd2;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("st_v", 32'(rsp_valid), 32'd1);
      chk("st_d", rsp_data, 32'hFF12_3456);
      chk("st_id", 32'(rsp_id), 32'd0);
      chk("st_busy", 32'(busy), 32'd1);
      chk("st_rdy0", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("st_idle", {30'd0, busy, rsp_valid}, 32'd0);
    #1;
    chk("st_g1", 32'(req1_ready), 32'd1);
    req1_valid = 1'b0;
    tick();

    run_job("z0", 1'b1, 32'hDEAD_BEEF, 6'd0, 32'hDEAD_BEEF, ZERO_K, 5'd0, 5'd0);

    // Reset lands while the job is in its second pass.
    req0_valid = 1'b1; req0_data = 32'h0; req0_amt = 6'd40;
    #1;
    chk("mr_rdy", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    chk("mr_p2ld", 32'(sh_load), 32'd9);
    rst_n = 1'b0;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("mr_rdy0", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("mr_rspv", 32'(rsp_valid), 32'd0);
    chk("mr_rspd", rsp_data, 32'd0);
    chk("mr_id", 32'(rsp_id), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_shin", sh_in, 32'd0);
    chk("mr_shld", 32'(sh_load), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mr_fav0", {30'd0, req1_ready, req0_ready}, 32'd1);
    req1_valid = 1'b0;
    run_job("mr_job", 1'b0, 32'h1, 6'd1, 32'h8000_0000, 1, 5'd1, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
